// File: rtl/regfile_pkg.sv
// regfile_sb shared defaults and types.
// Define REGFILE_BYPASS_EN for same-cycle writeback forwarding.
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int AW     = $clog2(NREG);
    localparam int PEND_W = 2;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [AW-1:0]     reg_idx_t;
    typedef logic [PEND_W-1:0] pend_t;

    localparam pend_t PEND_MAX = {PEND_W{1'b1}};

endpackage

// File: rtl/regfile_pend_ctr.sv
// Saturating pending-write counter for one register.
// Holds at full on inc and at zero on dec; inc+dec together cancel.
module regfile_pend_ctr #(
    parameter int W = regfile_pkg::PEND_W
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         nonzero,
    output logic         full
);
    import regfile_pkg::*;

    logic up;
    logic dn;

    assign nonzero = (count != '0);
    assign full    = &count;
    assign up      = inc && !full;
    assign dn      = dec && nonzero;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (up && !dn) begin
            count <= count + W'(1);
        end else if (dn && !up) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward writeback data/busy to readers.
module regfile_sb #(
    parameter int XLEN   = regfile_pkg::XLEN,
    parameter int NREG   = regfile_pkg::NREG,
    parameter int AW     = $clog2(NREG),
    parameter int PEND_W = regfile_pkg::PEND_W
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] RFrs1,
    output logic [XLEN-1:0] RFrs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            iss_ready,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] DataWr,
    input  logic            RFWr,
    output logic            wb_err
);
    import regfile_pkg::*;

    logic [XLEN-1:0]             rf [NREG];
    logic [NREG-1:0][PEND_W-1:0] cnt;
    logic [NREG-1:0]             nz;
    logic [NREG-1:0]             full;
    logic                        wr_en;
    logic                        iss_acc;

    assign wr_en     = RFWr && (rd != '0);
    assign iss_ready = (iss_rd == '0) || !full[iss_rd];
    assign iss_acc   = iss_valid && iss_ready;

    // x0 has no counter: never busy, never full
    assign cnt[0]  = '0;
    assign nz[0]   = 1'b0;
    assign full[0] = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_ctr
        regfile_pend_ctr #(
            .W(PEND_W)
        ) u_ctr (
            .CLK    (CLK),
            .RST_N  (RST_N),
            .inc    (iss_acc && (iss_rd == AW'(i))),
            .dec    (wr_en && (rd == AW'(i))),
            .count  (cnt[i]),
            .nonzero(nz[i]),
            .full   (full[i])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[rd] <= DataWr;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wb_err <= 1'b0;
        end else if (wr_en && !nz[rd]) begin
            wb_err <= 1'b1;
        end
    end

    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            bz1;
    logic            bz2;

    assign rd1 = (rs1 == '0) ? '0 : rf[rs1];
    assign rd2 = (rs2 == '0) ? '0 : rf[rs2];
    assign bz1 = (rs1 != '0) && (cnt[rs1] != '0);
    assign bz2 = (rs2 != '0) && (cnt[rs2] != '0);

`ifdef REGFILE_BYPASS_EN
    logic hit1;
    logic hit2;

    assign hit1 = wr_en && (rd == rs1);
    assign hit2 = wr_en && (rd == rs2);

    // a hit reader sees the retire as already done
    assign RFrs1    = hit1 ? DataWr : rd1;
    assign RFrs2    = hit2 ? DataWr : rd2;
    assign rs1_busy = hit1 ? (cnt[rs1] > PEND_W'(1)) : bz1;
    assign rs2_busy = hit2 ? (cnt[rs2] > PEND_W'(1)) : bz2;
`else
    assign RFrs1    = rd1;
    assign RFrs2    = rd2;
    assign rs1_busy = bz1;
    assign rs2_busy = bz2;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb.
// Honours REGFILE_BYPASS_EN when defined for the build.
module tb_regfile_sb;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  rs1, rs2, iss_rd, rd;
    logic [31:0] RFrs1, RFrs2, DataWr;
    logic        rs1_busy, rs2_busy;
    logic        iss_valid, iss_ready, RFWr, wb_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    regfile_sb dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .rs1      (rs1),
        .rs2      (rs2),
        .RFrs1    (RFrs1),
        .RFrs2    (RFrs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .iss_ready(iss_ready),
        .rd       (rd),
        .DataWr   (DataWr),
        .RFWr     (RFWr),
        .wb_err   (wb_err)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0; rs1 = 5'd5; rs2 = 5'd3;
        iss_valid = 1'b0; iss_rd = 5'd7;
        rd = 5'd0; DataWr = '0; RFWr = 1'b0;
        #2;
        n_cmp++;
        if (RFrs1 !== 32'h0) begin n_err++; $display("FAIL reset_rfrs1 got %h want %h", RFrs1, 32'h0); end
        n_cmp++;
        if (RFrs2 !== 32'h0) begin n_err++; $display("FAIL reset_rfrs2 got %h want %h", RFrs2, 32'h0); end
        n_cmp++;
        if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b%b want 00", rs1_busy, rs2_busy); end
        n_cmp++;
        if (iss_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", iss_ready); end
        n_cmp++;
        if (wb_err !== 1'b0) begin n_err++; $display("FAIL reset_wberr got %b want 0", wb_err); end
        step(); step();
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_write_read();
        iss_valid = 1'b1; iss_rd = 5'd3;
        step();
        iss_valid = 1'b0;
        rd = 5'd3; DataWr = 32'h12345678; RFWr = 1'b1;
        step();
        RFWr = 1'b0; rs2 = 5'd3;
        #1;
        n_cmp++;
        if (RFrs2 !== 32'h12345678) begin n_err++; $display("FAIL wr_x3 got %h want %h", RFrs2, 32'h12345678); end
        n_cmp++;
        if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL wr_x3_busy got %b want 0", rs2_busy); end
        rd = 5'd0; DataWr = 32'hFFFFFFFF; RFWr = 1'b1;
        step();
        RFWr = 1'b0; rs1 = 5'd0;
        #1;
        n_cmp++;
        if (RFrs1 !== 32'h0) begin n_err++; $display("FAIL wr_x0 got %h want %h", RFrs1, 32'h0); end
        n_cmp++;
        if (wb_err !== 1'b0) begin n_err++; $display("FAIL wr_x0_wberr got %b want 0", wb_err); end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        n_cmp++;
        if (iss_ready !== 1'b1) begin n_err++; $display("FAIL sb_ready0 got %b want 1", iss_ready); end
        step(); step(); step();
        n_cmp++;
        if (iss_ready !== 1'b0) begin n_err++; $display("FAIL sb_ready_full got %b want 0", iss_ready); end
        step();
        iss_valid = 1'b0; rs1 = 5'd7;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_busy3 got %b want 1", rs1_busy); end
        rd = 5'd7; DataWr = 32'h77; RFWr = 1'b1;
        step();
        RFWr = 1'b0;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || iss_ready !== 1'b1) begin n_err++; $display("FAIL sb_ret1 got busy=%b ready=%b want busy=1 ready=1", rs1_busy, iss_ready); end
        RFWr = 1'b1;
        step();
        RFWr = 1'b0;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sb_ret2 got %b want 1", rs1_busy); end
        RFWr = 1'b1;
        step();
        RFWr = 1'b0;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sb_ret3 got %b want 0", rs1_busy); end
        n_cmp++;
        if (wb_err !== 1'b0) begin n_err++; $display("FAIL sb_wberr got %b want 0", wb_err); end
    endtask

    task automatic test_same_cycle();
        iss_valid = 1'b1; iss_rd = 5'd9;
        step();
        rd = 5'd9; DataWr = 32'h99; RFWr = 1'b1;
        step();
        iss_valid = 1'b0; RFWr = 1'b0; rs1 = 5'd9;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || RFrs1 !== 32'h99) begin n_err++; $display("FAIL sim_x9 got busy=%b data=%h want busy=1 data=%h", rs1_busy, RFrs1, 32'h99); end
        RFWr = 1'b1;
        step();
        RFWr = 1'b0;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0 || wb_err !== 1'b0) begin n_err++; $display("FAIL sim_x9_drain got busy=%b err=%b want 0 0", rs1_busy, wb_err); end
    endtask

    task automatic test_sat_retire();
        iss_valid = 1'b1; iss_rd = 5'd10;
        step(); step(); step();
        rd = 5'd10; DataWr = 32'hA; RFWr = 1'b1;
        #1;
        n_cmp++;
        if (iss_ready !== 1'b0) begin n_err++; $display("FAIL sat_ready got %b want 0", iss_ready); end
        step();
        iss_valid = 1'b0; RFWr = 1'b0; rs2 = 5'd10;
        #1;
        n_cmp++;
        if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL sat_cnt2 got %b want 1", rs2_busy); end
        RFWr = 1'b1;
        step();
        RFWr = 1'b0;
        #1;
        n_cmp++;
        if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL sat_cnt1 got %b want 1", rs2_busy); end
        RFWr = 1'b1;
        step();
        RFWr = 1'b0;
        #1;
        n_cmp++;
        if (rs2_busy !== 1'b0 || wb_err !== 1'b0) begin n_err++; $display("FAIL sat_cnt0 got busy=%b err=%b want 0 0", rs2_busy, wb_err); end
    endtask

    task automatic test_bypass();
        iss_valid = 1'b1; iss_rd = 5'd6;
        step(); step();
        iss_valid = 1'b0;
        rd = 5'd6; DataWr = 32'h11111111; RFWr = 1'b1;
        step();
        DataWr = 32'hA5A5A5A5; rs1 = 5'd6; rs2 = 5'd6;
        #1;
`ifdef REGFILE_BYPASS_EN
        n_cmp++;
        if (RFrs1 !== 32'hA5A5A5A5 || rs1_busy !== 1'b0) begin n_err++; $display("FAIL byp_rs1 got %h/%b want %h/0", RFrs1, rs1_busy, 32'hA5A5A5A5); end
        n_cmp++;
        if (RFrs2 !== 32'hA5A5A5A5 || rs2_busy !== 1'b0) begin n_err++; $display("FAIL byp_rs2 got %h/%b want %h/0", RFrs2, rs2_busy, 32'hA5A5A5A5); end
`else
        n_cmp++;
        if (RFrs1 !== 32'h11111111 || rs1_busy !== 1'b1) begin n_err++; $display("FAIL nobyp_rs1 got %h/%b want %h/1", RFrs1, rs1_busy, 32'h11111111); end
        n_cmp++;
        if (RFrs2 !== 32'h11111111 || rs2_busy !== 1'b1) begin n_err++; $display("FAIL nobyp_rs2 got %h/%b want %h/1", RFrs2, rs2_busy, 32'h11111111); end
`endif
        step();
        RFWr = 1'b0;
        #1;
        n_cmp++;
        if (RFrs1 !== 32'hA5A5A5A5 || rs1_busy !== 1'b0) begin n_err++; $display("FAIL byp_after got %h/%b want %h/0", RFrs1, rs1_busy, 32'hA5A5A5A5); end
        n_cmp++;
        if (wb_err !== 1'b0) begin n_err++; $display("FAIL byp_wberr got %b want 0", wb_err); end
    endtask

    task automatic test_spurious();
        rd = 5'd4; DataWr = 32'hCAFEF00D; RFWr = 1'b1;
        step();
        RFWr = 1'b0; rs2 = 5'd4;
        #1;
        n_cmp++;
        if (RFrs2 !== 32'hCAFEF00D) begin n_err++; $display("FAIL spur_data got %h want %h", RFrs2, 32'hCAFEF00D); end
        n_cmp++;
        if (wb_err !== 1'b1 || rs2_busy !== 1'b0) begin n_err++; $display("FAIL spur_err got err=%b busy=%b want 1 0", wb_err, rs2_busy); end
        step(); step(); step();
        n_cmp++;
        if (wb_err !== 1'b1) begin n_err++; $display("FAIL spur_sticky got %b want 1", wb_err); end
    endtask

    task automatic test_reset_midstream();
        rd = 5'd5; DataWr = 32'hDEADBEEF; RFWr = 1'b1;
        step();
        RFWr = 1'b0; iss_valid = 1'b1; iss_rd = 5'd5;
        step();
        rs1 = 5'd5;
        #1;
        n_cmp++;
        if (RFrs1 !== 32'hDEADBEEF || rs1_busy !== 1'b1) begin n_err++; $display("FAIL mid_pre got %h/%b want %h/1", RFrs1, rs1_busy, 32'hDEADBEEF); end
        RST_N = 1'b0;
        #1;
        n_cmp++;
        if (RFrs1 !== 32'h0 || rs1_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_x5 got %h/%b want %h/0", RFrs1, rs1_busy, 32'h0); end
        n_cmp++;
        if (wb_err !== 1'b0 || iss_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_flags got err=%b ready=%b want 0 1", wb_err, iss_ready); end
        n_cmp++;
        if (RFrs2 !== 32'h0) begin n_err++; $display("FAIL mid_rst_x4 got %h want %h", RFrs2, 32'h0); end
        iss_valid = 1'b0;
        step();
        RST_N = 1'b1;
        step();
    endtask

    task automatic test_x0_issue();
        iss_valid = 1'b1; iss_rd = 5'd0; rs1 = 5'd0;
        step(); step(); step(); step();
        n_cmp++;
        if (iss_ready !== 1'b1 || rs1_busy !== 1'b0) begin n_err++; $display("FAIL x0_iss got ready=%b busy=%b want 1 0", iss_ready, rs1_busy); end
        iss_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_same_cycle();
        test_sat_retire();
        test_bypass();
        test_spurious();
        test_reset_midstream();
        test_x0_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
